branch_hazard_ctrl: RTL and testbench

Parametrised branch hazard controller for the ID-stage branch comparator of the 5-stage MIPS pipeline. It detects RAW dependencies between a branch's source registers and producers in EX, MEM and WB, and holds PC and IF/ID for a counted number of cycles while inserting EX bubbles. It then selects comparator forwarding paths and flushes IF/ID on a taken branch. It supersedes the single-cycle combinational branch stall unit with registered, multi-cycle stall control, a configurable load latency and an abort path.

---
 rtl/branch_hazard_pkg.sv | 30 +++
 rtl/branch_dep_check.sv | 51 +++++
 rtl/branch_hazard_ctrl.sv | 120 ++++++++++++
 tb/tb_branch_hazard_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_hazard_pkg.sv
// Shared types, forwarding selects and stall-count rule for the ID-stage
// branch hazard controller.
package branch_hazard_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    STG_EX  = 2'd0,
    STG_MEM = 2'd1,
    STG_WB  = 2'd2
  } stage_t;

  // Cycles a branch must hold before the producer's value can reach the comparator.
  function automatic int unsigned stall_count(input stage_t stage, input logic is_load,
                                              input int unsigned mem_lat);
    case (stage)
      STG_EX:  return is_load ? (1 + mem_lat) : 1;
      STG_MEM: return is_load ? mem_lat : 0;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/branch_dep_check.sv
// Per-operand dependency check: stall cycles needed and comparator forwarding select.
module branch_dep_check
  import branch_hazard_pkg::*;
#(
  parameter int REG_AW   = 3,
  parameter int MEM_LAT  = 1,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 2
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] rd_ex,
  input  logic              wen_ex,
  input  logic              load_ex,
  input  logic [REG_AW-1:0] rd_mem,
  input  logic              wen_mem,
  input  logic              load_mem,
  input  logic [REG_AW-1:0] rd_wb,
  input  logic              wen_wb,
  output logic [CNT_W-1:0]  cnt,
  output logic [1:0]        fwd
);

  localparam bit ZR = (ZERO_REG != 0);

  logic src_ok;
  logic dep_ex;
  logic dep_mem;
  logic dep_wb;

  assign src_ok  = !(ZR && (src == '0));
  assign dep_ex  = src_ok && wen_ex  && (rd_ex  == src);
  assign dep_mem = src_ok && wen_mem && (rd_mem == src);
  assign dep_wb  = src_ok && wen_wb  && (rd_wb  == src);

  // The youngest producer decides; an older match is shadowed by it.
  always_comb begin
    cnt = '0;
    fwd = FWD_RF;
    if (dep_ex) begin
      cnt = CNT_W'(stall_count(STG_EX, load_ex, MEM_LAT));
    end else if (dep_mem && load_mem) begin
      cnt = CNT_W'(stall_count(STG_MEM, 1'b1, MEM_LAT));
    end
    if (dep_mem) begin
      fwd = load_mem ? FWD_RF : FWD_EXMEM;
    end else if (dep_wb) begin
      fwd = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Branch hazard controller: combinational detection, registered multi-cycle
// stall release, comparator forwarding and IF/ID flush on taken branches.
module branch_hazard_ctrl
  import branch_hazard_pkg::*;
#(
  parameter int REG_AW   = 3,
  parameter int MEM_LAT  = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              branch_id,
  input  logic              taken_id,
  input  logic [REG_AW-1:0] rs_id,
  input  logic [REG_AW-1:0] rt_id,
  input  logic [REG_AW-1:0] rd_ex,
  input  logic              wen_ex,
  input  logic              load_ex,
  input  logic [REG_AW-1:0] rd_mem,
  input  logic              wen_mem,
  input  logic              load_mem,
  input  logic [REG_AW-1:0] rd_wb,
  input  logic              wen_wb,
  input  logic              kill,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              bubble_idex,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              flush_ifid
);

  localparam int CNT_W = $clog2(MEM_LAT + 2);

  logic [CNT_W-1:0] cnt_rs;
  logic [CNT_W-1:0] cnt_rt;
  logic [CNT_W-1:0] need;
  logic [1:0]       fwd_rs;
  logic [1:0]       fwd_rt;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             stall;

  branch_dep_check #(
    .REG_AW(REG_AW), .MEM_LAT(MEM_LAT), .ZERO_REG(ZERO_REG), .CNT_W(CNT_W)
  ) u_dep_rs (
    .src(rs_id), .rd_ex(rd_ex), .wen_ex(wen_ex), .load_ex(load_ex),
    .rd_mem(rd_mem), .wen_mem(wen_mem), .load_mem(load_mem),
    .rd_wb(rd_wb), .wen_wb(wen_wb), .cnt(cnt_rs), .fwd(fwd_rs)
  );

  branch_dep_check #(
    .REG_AW(REG_AW), .MEM_LAT(MEM_LAT), .ZERO_REG(ZERO_REG), .CNT_W(CNT_W)
  ) u_dep_rt (
    .src(rt_id), .rd_ex(rd_ex), .wen_ex(wen_ex), .load_ex(load_ex),
    .rd_mem(rd_mem), .wen_mem(wen_mem), .load_mem(load_mem),
    .rd_wb(rd_wb), .wen_wb(wen_wb), .cnt(cnt_rt), .fwd(fwd_rt)
  );

  assign need = (cnt_rs > cnt_rt) ? cnt_rs : cnt_rt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q holds the stall cycles still owed after the current one; the
  // detection cycle itself is the first stall, so a 1-cycle need never leaves IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (branch_id && !kill && (need != '0)) begin
          stall = 1'b1;
          if (need > CNT_W'(1)) begin
            state_d = WAIT;
            cnt_d   = need - CNT_W'(1);
          end
        end
      end
      WAIT: begin
        if (kill) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          stall = 1'b1;
          if (cnt_q <= CNT_W'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Every output is gated by rst_n so reset silences them even combinationally.
  assign stall_pc    = rst_n && stall;
  assign stall_ifid  = rst_n && stall;
  assign bubble_idex = rst_n && stall;
  assign fwd_a       = (rst_n && !stall) ? fwd_rs : FWD_RF;
  assign fwd_b       = (rst_n && !stall) ? fwd_rt : FWD_RF;
  assign flush_ifid  = rst_n && branch_id && taken_id && !stall && !kill;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl: single-cycle vector table plus
// multi-cycle stall, kill, flush and reset sequences at MEM_LAT 1 and 3.
module tb_branch_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       branch_id, taken_id, kill;
  logic [2:0] rs_id, rt_id, rd_ex, rd_mem, rd_wb;
  logic       wen_ex, load_ex, wen_mem, load_mem, wen_wb;

  logic       s_pc1, s_ifid1, bub1, fl1;
  logic [1:0] fa1, fb1;
  logic       s_pc3, s_ifid3, bub3, fl3;
  logic [1:0] fa3, fb3;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  branch_hazard_ctrl #(.REG_AW(3), .MEM_LAT(1), .ZERO_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .branch_id(branch_id), .taken_id(taken_id),
    .rs_id(rs_id), .rt_id(rt_id), .rd_ex(rd_ex), .wen_ex(wen_ex), .load_ex(load_ex),
    .rd_mem(rd_mem), .wen_mem(wen_mem), .load_mem(load_mem),
    .rd_wb(rd_wb), .wen_wb(wen_wb), .kill(kill),
    .stall_pc(s_pc1), .stall_ifid(s_ifid1), .bubble_idex(bub1),
    .fwd_a(fa1), .fwd_b(fb1), .flush_ifid(fl1)
  );

  branch_hazard_ctrl #(.REG_AW(3), .MEM_LAT(3), .ZERO_REG(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .branch_id(branch_id), .taken_id(taken_id),
    .rs_id(rs_id), .rt_id(rt_id), .rd_ex(rd_ex), .wen_ex(wen_ex), .load_ex(load_ex),
    .rd_mem(rd_mem), .wen_mem(wen_mem), .load_mem(load_mem),
    .rd_wb(rd_wb), .wen_wb(wen_wb), .kill(kill),
    .stall_pc(s_pc3), .stall_ifid(s_ifid3), .bubble_idex(bub3),
    .fwd_a(fa3), .fwd_b(fb3), .flush_ifid(fl3)
  );

  typedef struct {
    logic       br, tk;
    logic [2:0] rs, rt, rex;
    logic       wex, lex;
    logic [2:0] rmem;
    logic       wmem, lmem;
    logic [2:0] rwb;
    logic       wwb, kl;
    logic       xs;
    logic [1:0] xa, xb;
    logic       xf;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic br, logic tk, logic [2:0] rs, logic [2:0] rt,
                              logic [2:0] rex, logic wex, logic lex,
                              logic [2:0] rmem, logic wmem, logic lmem,
                              logic [2:0] rwb, logic wwb, logic kl,
                              logic xs, logic [1:0] xa, logic [1:0] xb, logic xf);
    vec_t v;
    v.br = br; v.tk = tk; v.rs = rs; v.rt = rt; v.rex = rex; v.wex = wex; v.lex = lex;
    v.rmem = rmem; v.wmem = wmem; v.lmem = lmem; v.rwb = rwb; v.wwb = wwb; v.kl = kl;
    v.xs = xs; v.xa = xa; v.xb = xb; v.xf = xf;
    return v;
  endfunction

  function automatic logic [7:0] ex(logic s, logic [1:0] a, logic [1:0] b, logic f);
    return {s, s, s, a, b, f};
  endfunction

  function automatic logic [7:0] o1();
    return {s_pc1, s_ifid1, bub1, fa1, fb1, fl1};
  endfunction

  function automatic logic [7:0] o3();
    return {s_pc3, s_ifid3, bub3, fa3, fb3, fl3};
  endfunction

  task automatic chk(string nm, logic [7:0] got, logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {stall3,fa,fb,flush}=%b required %b", nm, got, exp);
    end
  endtask

  task automatic idle();
    branch_id = 0; taken_id = 0; kill = 0;
    rs_id = 0; rt_id = 0;
    rd_ex = 0; wen_ex = 0; load_ex = 0;
    rd_mem = 0; wen_mem = 0; load_mem = 0;
    rd_wb = 0; wen_wb = 0;
  endtask

  task automatic drive(vec_t v);
    branch_id = v.br; taken_id = v.tk; kill = v.kl;
    rs_id = v.rs; rt_id = v.rt;
    rd_ex = v.rex; wen_ex = v.wex; load_ex = v.lex;
    rd_mem = v.rmem; wen_mem = v.wmem; load_mem = v.lmem;
    rd_wb = v.rwb; wen_wb = v.wwb;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One idle cycle with kill to return both controllers to IDLE.
  task automatic clear();
    cyc(); idle(); kill = 1;
    cyc(); idle();
  endtask

  task automatic ex_load_rt5();
    idle(); branch_id = 1; rt_id = 5; rs_id = 1;
    rd_ex = 5; wen_ex = 1; load_ex = 1;
  endtask

  task automatic mem_load_rt5();
    rd_ex = 0; wen_ex = 0; load_ex = 0;
    rd_mem = 5; wen_mem = 1; load_mem = 1;
  endtask

  task automatic wb_rt5();
    rd_ex = 0; wen_ex = 0; load_ex = 0;
    rd_mem = 0; wen_mem = 0; load_mem = 0;
    rd_wb = 5; wen_wb = 1;
  endtask

  initial begin
    //          br tk rs rt rex wex lex rmem wmem lmem rwb wwb kl | s  fa     fb     f
    vq.push_back(mk(0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
    vq.push_back(mk(1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1));
    vq.push_back(mk(1, 1, 2, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0));
    vq.push_back(mk(1, 0, 1, 5, 5, 1, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0));
    vq.push_back(mk(1, 1, 4, 1, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 1));
    vq.push_back(mk(1, 0, 4, 1, 0, 0, 0, 4, 1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 0));
    vq.push_back(mk(1, 0, 1, 6, 0, 0, 0, 0, 0, 0, 6, 1, 0, 0, 2'b00, 2'b10, 0));
    vq.push_back(mk(1, 0, 3, 1, 0, 0, 0, 3, 1, 0, 3, 1, 0, 0, 2'b01, 2'b00, 0));
    vq.push_back(mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
    vq.push_back(mk(1, 0, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
    vq.push_back(mk(1, 1, 2, 1, 2, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0));
    vq.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
    vq.push_back(mk(1, 0, 2, 6, 2, 1, 0, 0, 0, 0, 6, 1, 0, 1, 2'b00, 2'b00, 0));
    vq.push_back(mk(0, 1, 2, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
    vq.push_back(mk(1, 0, 5, 5, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 2'b01, 2'b01, 0));

    // Reset holds every output low despite a live hazard and taken branch.
    rst_n = 0; idle();
    branch_id = 1; taken_id = 1; rs_id = 3; rd_ex = 3; wen_ex = 1;
    cyc(); cyc(); #4;
    chk("reset_dut1", o1(), ex(0, 2'b00, 2'b00, 0));
    chk("reset_dut3", o3(), ex(0, 2'b00, 2'b00, 0));
    cyc(); rst_n = 1; #4;
    chk("reset_release_stall", o1(), ex(1, 2'b00, 2'b00, 0));
    cyc(); rd_ex = 0; wen_ex = 0; rd_mem = 3; wen_mem = 1; #4;
    chk("reset_release_resolve", o1(), ex(0, 2'b01, 2'b00, 1));
    clear();

    foreach (vq[i]) begin
      cyc(); drive(vq[i]); #4;
      chk($sformatf("vec%0d", i), o1(), ex(vq[i].xs, vq[i].xa, vq[i].xb, vq[i].xf));
      cyc(); idle(); kill = 1;
    end
    cyc(); idle();

    // EX load at MEM_LAT=1: two stall cycles then WB forwarding.
    cyc(); ex_load_rt5(); #4;
    chk("exld1_c0", o1(), ex(1, 2'b00, 2'b00, 0));
    cyc(); mem_load_rt5(); #4;
    chk("exld1_c1", o1(), ex(1, 2'b00, 2'b00, 0));
    cyc(); wb_rt5(); #4;
    chk("exld1_resolve", o1(), ex(0, 2'b00, 2'b10, 0));
    clear();

    // EX load at MEM_LAT=3: four stall cycles.
    cyc(); ex_load_rt5(); #4;
    chk("exld3_c0", o3(), ex(1, 2'b00, 2'b00, 0));
    for (int c = 1; c < 4; c++) begin
      cyc(); mem_load_rt5(); #4;
      chk($sformatf("exld3_c%0d", c), o3(), ex(1, 2'b00, 2'b00, 0));
    end
    cyc(); wb_rt5(); #4;
    chk("exld3_resolve", o3(), ex(0, 2'b00, 2'b10, 0));
    clear();

    // kill in the second stall cycle drops the stall at once.
    cyc(); ex_load_rt5(); #4;
    chk("kill_c0", o1(), ex(1, 2'b00, 2'b00, 0));
    cyc(); mem_load_rt5(); kill = 1; #4;
    chk("kill_c1", o1(), ex(0, 2'b00, 2'b00, 0));
    cyc(); idle(); branch_id = 1; taken_id = 1; rs_id = 1; rt_id = 5; #4;
    chk("kill_idle_after", o1(), ex(0, 2'b00, 2'b00, 1));
    clear();

    // Taken branch behind a stall flushes only once it resolves.
    cyc(); ex_load_rt5(); taken_id = 1; #4;
    chk("flush_c0", o1(), ex(1, 2'b00, 2'b00, 0));
    cyc(); mem_load_rt5(); #4;
    chk("flush_c1", o1(), ex(1, 2'b00, 2'b00, 0));
    cyc(); wb_rt5(); #4;
    chk("flush_resolve", o1(), ex(0, 2'b00, 2'b10, 1));
    cyc(); idle(); #4;
    chk("flush_after", o1(), ex(0, 2'b00, 2'b00, 0));
    clear();

    // rs on EX load (2) and rt on MEM load (1): the larger count wins.
    cyc(); idle(); branch_id = 1; rs_id = 2; rt_id = 6;
    rd_ex = 2; wen_ex = 1; load_ex = 1; rd_mem = 6; wen_mem = 1; load_mem = 1; #4;
    chk("max_c0", o1(), ex(1, 2'b00, 2'b00, 0));
    cyc(); rd_ex = 0; wen_ex = 0; load_ex = 0; rd_mem = 2; #4;
    chk("max_c1", o1(), ex(1, 2'b00, 2'b00, 0));
    cyc(); rd_mem = 0; wen_mem = 0; load_mem = 0; rd_wb = 2; wen_wb = 1; #4;
    chk("max_resolve", o1(), ex(0, 2'b10, 2'b00, 0));
    clear();

    // Reset asserted mid-WAIT discards the stall.
    cyc(); ex_load_rt5(); taken_id = 1; #4;
    chk("rstwait_c0", o3(), ex(1, 2'b00, 2'b00, 0));
    cyc(); rst_n = 0; #4;
    chk("rstwait_in_reset", o3(), ex(0, 2'b00, 2'b00, 0));
    cyc(); rst_n = 1; idle(); branch_id = 1; taken_id = 1; rs_id = 1; rt_id = 2; #4;
    chk("rstwait_idle", o3(), ex(0, 2'b00, 2'b00, 1));
    cyc(); idle();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
